// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_t;

  localparam int SPI_BITS = 8;
  localparam int DIV_MAX  = 255;
  localparam int DIV_W    = $clog2(DIV_MAX + 1);
  localparam int BIT_W    = $clog2(SPI_BITS);

  // MISO enters at the LSB so the first (MSB) bit ends up at the top after eight samples.
  function automatic logic [SPI_BITS-1:0] shift_in(input logic [SPI_BITS-1:0] sh,
                                                   input logic bit_in);
    return {sh[SPI_BITS-2:0], bit_in};
  endfunction

  function automatic logic is_last_bit(input logic [BIT_W-1:0] cnt);
    return (cnt == BIT_W'(SPI_BITS - 1));
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase-length counter: counts 0..CLK_DIV-1 and flags the last cycle as a tick.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  // Next count: restart on clear or on wrap.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr || tick) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= {DIV_W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 byte master: drives SCLK/CS_N, strobes an external PISO for MOSI,
// and assembles the MISO byte returned during the same transfer.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic [7:0] piso_data,
  output logic       piso_load,
  output logic       piso_shift_en,
  output logic       busy
);

  spi_state_t          state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [7:0]          piso_data_q, piso_data_d;
  logic                piso_load_q, piso_load_d;
  logic                piso_shift_en_q, piso_shift_en_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;
  logic                busy_q, busy_d;
  logic                div_clr;
  logic                tick;

  // Every phase starts counting from zero; IDLE keeps the counter parked.
  assign div_clr = (state_d != state_q) || (state_q == ST_IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .tick (tick)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    sclk_d          = sclk_q;
    cs_n_d          = cs_n_q;
    piso_data_d     = piso_data_q;
    piso_load_d     = 1'b0;
    piso_shift_en_d = 1'b0;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    tx_ready_d      = tx_ready_q;
    busy_d          = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          piso_data_d = tx_data;
          piso_load_d = 1'b1;
          cs_n_d      = 1'b0;
          bit_cnt_d   = {BIT_W{1'b0}};
          rx_shift_d  = {SPI_BITS{1'b0}};
          tx_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_LEAD;
        end else begin
          sclk_d     = 1'b0;
          cs_n_d     = 1'b1;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          sclk_d     = 1'b1;
          rx_shift_d = shift_in(rx_shift_q, miso);
          state_d    = ST_HIGH;
        end else begin
          sclk_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          // The PISO advances on the falling edge, except after the final bit.
          if (is_last_bit(bit_cnt_q)) begin
            state_d = ST_TRAIL;
          end else begin
            piso_shift_en_d = 1'b1;
            bit_cnt_d       = bit_cnt_q + {{(BIT_W-1){1'b0}}, 1'b1};
            state_d         = ST_LOW;
          end
        end else begin
          sclk_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick) begin
          sclk_d     = 1'b1;
          rx_shift_d = shift_in(rx_shift_q, miso);
          state_d    = ST_HIGH;
        end else begin
          sclk_d = 1'b0;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = ST_GAP;
        end else begin
          cs_n_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cs_n_d = 1'b1;
        end
      end
      default: begin
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= {BIT_W{1'b0}};
      rx_shift_q      <= {SPI_BITS{1'b0}};
      sclk_q          <= 1'b0;
      cs_n_q          <= 1'b1;
      piso_data_q     <= 8'h00;
      piso_load_q     <= 1'b0;
      piso_shift_en_q <= 1'b0;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      tx_ready_q      <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      sclk_q          <= sclk_d;
      cs_n_q          <= cs_n_d;
      piso_data_q     <= piso_data_d;
      piso_load_q     <= piso_load_d;
      piso_shift_en_q <= piso_shift_en_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      tx_ready_q      <= tx_ready_d;
      busy_q          <= busy_d;
    end
  end

  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign piso_data     = piso_data_q;
  assign piso_load     = piso_load_q;
  assign piso_shift_en = piso_shift_en_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign tx_ready      = tx_ready_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: two instances (CLK_DIV=5 and 2), a PISO
// model for MOSI, a mode-0 slave echo model for MISO.
module tb_spi_master_ctrl;

  localparam int D5 = 5;
  localparam int D2 = 2;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic [7:0] rx_data [2];
  logic       rx_valid [2];
  logic       miso [2];
  logic       mosi [2];
  logic       sclk [2];
  logic       cs_n [2];
  logic [7:0] piso_data [2];
  logic       piso_load [2];
  logic       piso_shift_en [2];
  logic       busy [2];
  logic [7:0] echo [2];
  logic [7:0] slave_sh [2];
  logic [7:0] piso_sh [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl #(.CLK_DIV(D5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .miso(miso[0]), .sclk(sclk[0]), .cs_n(cs_n[0]), .piso_data(piso_data[0]),
    .piso_load(piso_load[0]), .piso_shift_en(piso_shift_en[0]), .busy(busy[0])
  );

  spi_master_ctrl #(.CLK_DIV(D2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .miso(miso[1]), .sclk(sclk[1]), .cs_n(cs_n[1]), .piso_data(piso_data[1]),
    .piso_load(piso_load[1]), .piso_shift_en(piso_shift_en[1]), .busy(busy[1])
  );

  // Serializer model: load on piso_load, shift MSB-first on piso_shift_en.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) piso_sh[i] <= 8'h00;
      else if (piso_load[i]) piso_sh[i] <= piso_data[i];
      else if (piso_shift_en[i]) piso_sh[i] <= {piso_sh[i][6:0], 1'b0};
    end
  end

  assign mosi[0] = piso_sh[0][7];
  assign mosi[1] = piso_sh[1][7];
  assign miso[0] = slave_sh[0][7];
  assign miso[1] = slave_sh[1][7];

  function automatic int div_of(input int i);
    return (i == 0) ? D5 : D2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] tx, input logic [7:0] rx, input int at);
    exp_t e;
    e.tx = tx;
    e.rx = rx;
    e.at = at;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor + slave model: sampled on the falling clk edge.
  initial begin
    int         rises [2];
    int         shifts [2];
    int         last_rise [2];
    logic [7:0] mosi_acc [2];
    logic       sclk_prev [2];
    logic       cs_prev [2];
    exp_t       e;
    bit         got;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; shifts[i] = 0; last_rise[i] = -1; mosi_acc[i] = 8'h00;
      sclk_prev[i] = 1'b0; cs_prev[i] = 1'b1; slave_sh[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          last_rise[i] = -1;
        end else begin
          // Mode-0 slave: first bit out when CS_N falls, next bit on each SCLK fall.
          if (cs_prev[i] && !cs_n[i]) slave_sh[i] = echo[i];
          else if (sclk_prev[i] && !sclk[i]) slave_sh[i] = {slave_sh[i][6:0], 1'b0};
          if (piso_load[i]) begin
            rises[i] = 0; shifts[i] = 0; mosi_acc[i] = 8'h00; last_rise[i] = -1;
          end
          if (piso_shift_en[i]) shifts[i]++;
          if (sclk[i] && !sclk_prev[i]) begin
            rises[i]++;
            mosi_acc[i] = {mosi_acc[i][6:0], mosi[i]};
            if (last_rise[i] >= 0)
              check($sformatf("d%0d_sclk_period", div_of(i)), cyc - last_rise[i], 2 * div_of(i));
            last_rise[i] = cyc;
          end
          if (!sclk[i] && sclk_prev[i] && last_rise[i] >= 0)
            check($sformatf("d%0d_sclk_high", div_of(i)), cyc - last_rise[i], div_of(i));
          if (rx_valid[i]) begin
            got = 1'b0;
            if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
              checks++;
              failures++;
              $display("FAIL d%0d_unexpected_rx_valid: actual rx_data=%0h at cycle %0d required no pulse",
                       div_of(i), rx_data[i], cyc);
            end else begin
              check($sformatf("d%0d_rx_data", div_of(i)), rx_data[i], e.rx);
              check($sformatf("d%0d_rx_cycle", div_of(i)), cyc, e.at);
              check($sformatf("d%0d_mosi_bits", div_of(i)), mosi_acc[i], e.tx);
              check($sformatf("d%0d_sclk_rises", div_of(i)), rises[i], 8);
              check($sformatf("d%0d_shift_pulses", div_of(i)), shifts[i], 7);
            end
          end
        end
        sclk_prev[i] = sclk[i];
        cs_prev[i]   = cs_n[i];
      end
    end
  end

  // Directed stimulus. Accept in cycle A: rx_valid is seen in cycle A+17*DIV+1
  // (registered on the TRAIL tick), tx_ready returns in cycle A+18*DIV+1.
  initial begin
    int a, b, m, d, bad_ready, bad_cs;
    tx_valid[0] = 1'b1; tx_valid[1] = 1'b0;
    tx_data[0]  = 8'hA5; tx_data[1] = 8'h00;
    echo[0]     = 8'h3C; echo[1] = 8'h00;

    // Reset held with tx_valid high: nothing may start.
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk[0], 1'b0);
    check("rst_cs_n", cs_n[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_piso_load", piso_load[0], 1'b0);
    check("rst_rx_valid", rx_valid[0], 1'b0);
    check("rst_rx_data", rx_data[0], 8'h00);
    check("rst_piso_data", piso_data[0], 8'h00);
    a = cyc;
    rst_n = 1'b1;
    push_exp(0, 8'hA5, 8'h3C, a + 17 * D5 + 1);
    #1 check("rel_tx_ready", tx_ready[0], 1'b1);
    @(negedge clk);
    check("acc_cs_n", cs_n[0], 1'b0);
    check("acc_piso_load", piso_load[0], 1'b1);
    check("acc_piso_data", piso_data[0], 8'hA5);
    check("acc_tx_ready", tx_ready[0], 1'b0);
    check("acc_busy", busy[0], 1'b1);
    tx_valid[0] = 1'b0;
    @(negedge clk);
    check("load_one_cycle", piso_load[0], 1'b0);
    wait_until(a + 18 * D5);
    check("ready_before_return", tx_ready[0], 1'b0);
    @(negedge clk);
    check("ready_return", tx_ready[0], 1'b1);
    check("busy_return", busy[0], 1'b0);

    // Back-to-back with tx_valid held: FF then 00.
    b = cyc;
    tx_data[0] = 8'hFF; echo[0] = 8'h0F; tx_valid[0] = 1'b1;
    push_exp(0, 8'hFF, 8'h0F, b + 17 * D5 + 1);
    push_exp(0, 8'h00, 8'hF0, b + 18 * D5 + 1 + 17 * D5 + 1);
    bad_ready = 0; bad_cs = 0;
    for (int k = 1; k <= 18 * D5 + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin tx_data[0] = 8'h00; echo[0] = 8'hF0; end
      if (k <= 18 * D5 && tx_ready[0] !== 1'b0) bad_ready++;
      // CS_N rises with rx_valid, stays high through GAP and the accept cycle.
      if (k <= 17 * D5 && cs_n[0] !== 1'b0) bad_cs++;
      if (k > 17 * D5 && cs_n[0] !== 1'b1) bad_cs++;
    end
    check("b2b_ready_low", bad_ready, 0);
    check("b2b_second_accept", tx_ready[0], 1'b1);
    check("b2b_cs_gap", bad_cs, 0);
    @(negedge clk);
    check("b2b_cs_low_again", cs_n[0], 1'b0);
    check("b2b_piso_data", piso_data[0], 8'h00);
    tx_valid[0] = 1'b0;

    // tx_valid pulsed while busy must be ignored.
    wait_until(b + 120);
    tx_data[0] = 8'h77; tx_valid[0] = 1'b1;
    check("busy_tx_ready", tx_ready[0], 1'b0);
    check("busy_flag", busy[0], 1'b1);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    bad_ready = 0;
    while (cyc < b + 2 * (18 * D5 + 1)) begin
      @(negedge clk);
      if (cyc < b + 2 * (18 * D5 + 1) && tx_ready[0] !== 1'b0) bad_ready++;
    end
    check("busy_ready_low_throughout", bad_ready, 0);
    check("b2b_end_ready", tx_ready[0], 1'b1);
    bad_cs = 0;
    repeat (40) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1) bad_cs++;
    end
    check("no_extra_transfer", bad_cs, 0);

    // Reset after the 4th SCLK rise, then a clean transfer.
    m = cyc;
    tx_data[0] = 8'h33; echo[0] = 8'hAA; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_until(m + 7 * D5 + 2);
    check("mid_sclk_high", sclk[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n[0], 1'b1);
    check("mid_rst_sclk", sclk[0], 1'b0);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_rx_valid", rx_valid[0], 1'b0);
    check("mid_rst_rx_data", rx_data[0], 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m = cyc;
    tx_data[0] = 8'h5A; echo[0] = 8'hC5; tx_valid[0] = 1'b1;
    push_exp(0, 8'h5A, 8'hC5, m + 17 * D5 + 1);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_until(m + 18 * D5 + 2);

    // Minimum divider.
    d = cyc;
    tx_data[1] = 8'h81; echo[1] = 8'h7E; tx_valid[1] = 1'b1;
    push_exp(1, 8'h81, 8'h7E, d + 17 * D2 + 1);
    @(negedge clk);
    tx_valid[1] = 1'b0;
    wait_until(d + 18 * D2 + 1);
    check("d2_ready_return", tx_ready[1], 1'b1);
    repeat (5) @(negedge clk);

    check("q5_drained", q0.size(), 0);
    check("q2_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: actual cycle=%0d required completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
